bin_to_bcd_seq: RTL
===================

// Module: bin_to_bcd_seq
// PURPOSE
//  Sequential binary-to-BCD converter (shift-and-add-3). Takes an unsigned binary
//  value on a start pulse and, BIN_W cycles later, presents DIGITS packed BCD
//  digits. Sits directly upstream of the per-digit seven-segment decoders on the
//  board display path; each 4-bit nibble of bcd_out drives one decoder input.
// PARAMETERS
//  BIN_W   16  width of binary input, >= 1
//  DIGITS   5  number of BCD output digits, >= 1
// PORTS
//  clk       in   1          system clock, rising edge
//  rst_n     in   1          asynchronous active-low reset
//  start     in   1          request conversion of bin_in; sampled only in IDLE
//  bin_in    in   BIN_W      unsigned binary operand, sampled with start
//  busy      out  1          high while a conversion is in progress
//  done      out  1          one-cycle pulse: bcd_out/overflow just updated
//  bcd_out   out  4*DIGITS   packed BCD result; digit k = bcd_out[4k+3:4k], k=0 units
//  overflow  out  1          result exceeded 10^DIGITS-1 (bcd_out = value mod 10^DIGITS)
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE, busy=0, done=0, bcd_out=0,
//    overflow=0, internal shift/count registers cleared. Reset mid-conversion
//    aborts it; no done pulse is produced for the aborted operation.
//  - States: IDLE, CONV.
//    IDLE: busy=0. On rising edge with start=1: latch bin_in into shift reg,
//      clear BCD scratch and overflow scratch, load count=BIN_W, go CONV.
//    CONV: busy=1. Each edge: (1) every scratch digit >=5 gets +3 (4-bit add,
//      no carry between digits); (2) {ovf_scratch, scratch, shift} shifted left 1;
//      MSB leaving scratch ORs into ovf_scratch; count decrements.
//      On the edge where count goes 1->0: bcd_out<=adjusted/shifted scratch,
//      overflow<=final ovf_scratch, done<=1, go IDLE.
//  - done is registered, high exactly one cycle (the first IDLE cycle), then 0.
//  - Latency: start sampled at edge E0 -> busy=1 after E0 -> results and done=1
//    after edge E_BIN_W (BIN_W cycles). Throughput: one conversion per BIN_W+1 cycles.
//  - start while busy=1 is ignored (no queueing, operands not re-latched).
//  - start high during the done cycle is accepted (state is IDLE): back-to-back OK;
//    bcd_out keeps the just-finished result until the next completion.
//  - bcd_out/overflow change only on completion; stable otherwise, incl. during CONV.
//  - bin_in changes after the start edge have no effect on the running conversion.
//  - Held start: re-triggers a new conversion each time IDLE is entered.
//  - Scratch digits never exceed 9 after completion for any input; DIGITS large
//    enough (>= ceil(BIN_W*log10(2))) guarantees overflow=0.
// TESTING
//  1 reset, start bin_in=0 -> after 16 cycles done=1, bcd_out=20'h00000, overflow=0
//  2 bin_in=16'd65535 -> bcd_out=20'h65535; bin_in=16'd1234 -> 20'h01234; done one cycle
//  3 start asserted in done cycle with 16'd9999 -> second done exactly 17 cycles after
//    first, bcd_out=20'h09999; start pulses while busy ignored (result unchanged)
//  4 rst_n low at cycle 8 of a conversion -> busy=0, bcd_out=0 immediately; no done
//    pulse until a new start
//  5 DIGITS=4: bin_in=16'd10000 -> bcd_out=16'h0000, overflow=1; 16'd12345 ->
//    16'h2345, overflow=1; 16'd9999 -> 16'h9999, overflow=0
//  6 random 16-bit sweep vs. reference model (digit k = (v/10^k)%10), >=1000 vectors

Source files
------------

// File: rtl/bin_to_bcd_seq_if.sv
// bin_to_bcd_seq_if: request/result bundle for the sequential binary-to-BCD
// converter.
//   start     requester -> converter  begin a conversion of bin_in
//   bin_in    requester -> converter  unsigned operand, sampled with start
//   busy      converter -> requester  conversion in progress
//   done      converter -> requester  one-cycle pulse, bcd_out/overflow updated
//   bcd_out   converter -> requester  packed BCD result, nibble k = 10^k digit
//   overflow  converter -> requester  value did not fit in DIGITS digits
// master = requester side, slave = converter side.
interface bin_to_bcd_seq_if #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
);
  logic                  start;
  logic [BIN_W-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  overflow;

  modport master (
    output start, bin_in,
    input  busy, done, bcd_out, overflow
  );

  modport slave (
    input  start, bin_in,
    output busy, done, bcd_out, overflow
  );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential shift-and-add-3 (double dabble) binary-to-BCD
// converter. One operand bit is consumed per clock, so a conversion takes
// BIN_W cycles after the start edge; the result feeds per-digit 7-segment
// decoders directly.
// Ports:
//   clk    rising-edge system clock
//   rst_n  asynchronous active-low reset
//   bus    bin_to_bcd_seq_if.slave: start/bin_in in; busy/done/bcd_out/overflow out
module bin_to_bcd_seq #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  bin_to_bcd_seq_if.slave   bus
);

  localparam int CW = $clog2(BIN_W + 1);
  localparam logic [CW-1:0] COUNT_LOAD = CW'(BIN_W);
  localparam logic [CW-1:0] COUNT_ONE  = CW'(1);

  typedef enum logic {IDLE, CONV} state_t;

  state_t              state_reg,    state_next;
  logic [BIN_W-1:0]    shift_reg,    shift_next;
  logic [4*DIGITS-1:0] scratch_reg,  scratch_next;
  logic                ovf_reg,      ovf_next;
  logic [CW-1:0]       count_reg,    count_next;
  logic [4*DIGITS-1:0] bcd_reg,      bcd_next;
  logic                overflow_reg, overflow_next;
  logic                done_reg,     done_next;

  // Per-digit add-3 correction applied before each shift. Digits are
  // corrected independently; a corrected digit never exceeds 4'hC so no
  // carry into the next nibble is needed.
  logic [4*DIGITS-1:0] adjusted;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      always_comb begin
        if (scratch_reg[4*gi +: 4] >= 4'd5)
          adjusted[4*gi +: 4] = scratch_reg[4*gi +: 4] + 4'd3;
        else
          adjusted[4*gi +: 4] = scratch_reg[4*gi +: 4];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      shift_reg    <= '0;
      scratch_reg  <= '0;
      ovf_reg      <= 1'b0;
      count_reg    <= '0;
      bcd_reg      <= '0;
      overflow_reg <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      shift_reg    <= shift_next;
      scratch_reg  <= scratch_next;
      ovf_reg      <= ovf_next;
      count_reg    <= count_next;
      bcd_reg      <= bcd_next;
      overflow_reg <= overflow_next;
      done_reg     <= done_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    shift_next    = shift_reg;
    scratch_next  = scratch_reg;
    ovf_next      = ovf_reg;
    count_next    = count_reg;
    bcd_next      = bcd_reg;
    overflow_next = overflow_reg;
    done_next     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          shift_next   = bus.bin_in;
          scratch_next = '0;
          ovf_next     = 1'b0;
          count_next   = COUNT_LOAD;
          state_next   = CONV;
        end
      end
      CONV: begin
        shift_next   = shift_reg << 1;
        scratch_next = {adjusted[4*DIGITS-2:0], shift_reg[BIN_W-1]};
        // A set MSB after correction means that digit reached >= 10 when
        // doubled, i.e. the value no longer fits in DIGITS digits; sticky.
        ovf_next     = ovf_reg | adjusted[4*DIGITS-1];
        count_next   = count_reg - COUNT_ONE;
        if (count_reg == COUNT_ONE) begin
          bcd_next      = scratch_next;
          overflow_next = ovf_next;
          done_next     = 1'b1;
          state_next    = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.busy     = (state_reg == CONV);
  assign bus.done     = done_reg;
  assign bus.bcd_out  = bcd_reg;
  assign bus.overflow = overflow_reg;

endmodule
